pushbutton_reader: RTL
======================

PUSHBUTTON_READER -- requirements
Module: pushbutton_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, stable-input cycles needed to accept a press or release; legal range 2..2^24.
REQ-002 Parameter LONG_CYCLES, default 20000000, debounced-hold cycles that classify a press as long; shall exceed DEBOUNCE_CYCLES and be at most 2^26.
REQ-003 clk  input  1  single system clock (Sys_Clk0 domain); all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
REQ-006 pressed  output  1  debounced button level, 1 = held.
REQ-007 short_press  output  1  one-cycle pulse, released press shorter than LONG_CYCLES.
REQ-008 long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-009 toggle  output  1  flips on every short_press; drives an LED directly.

Function
REQ-010 btn_n shall pass through a two-flop synchronizer; its inverted output btn_s (1 = pressed) is the only input seen by the FSM.
REQ-011 FSM states: IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE; all outputs registered.
REQ-012 IDLE: btn_s=1 -> DEB_PRESS, debounce count dcnt cleared to 0.
REQ-013 DEB_PRESS: btn_s=0 -> IDLE (bounce rejected, no output change); else dcnt+1; when dcnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD, pressed=1, hold count hcnt cleared to 0, long flag cleared.
REQ-014 Press latency: pressed shall rise on rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples btn_n low, provided btn_n stays low.
REQ-015 HELD: btn_s=1 -> hcnt+1; when hcnt==LONG_CYCLES-1 with btn_s=1 -> LONG_HELD, long flag set, long_press=1 for exactly one cycle (LONG_CYCLES edges after pressed rose).
REQ-016 HELD or LONG_HELD with btn_s=0 -> DEB_RELEASE, dcnt cleared to 0; hcnt frozen; pressed stays 1.
REQ-017 Simultaneous event: hcnt==LONG_CYCLES-1 and btn_s=0 in the same cycle -> release wins; DEB_RELEASE, no long_press.
REQ-018 DEB_RELEASE: btn_s=1 -> back to HELD (long flag clear) or LONG_HELD (long flag set), hcnt resumes from frozen value; btn_s=0 -> dcnt+1; when dcnt==DEBOUNCE_CYCLES-1 -> IDLE, pressed=0.
REQ-019 On the DEB_RELEASE->IDLE transition with long flag clear: short_press=1 for one cycle and toggle inverts in the same cycle; with long flag set: no pulse, toggle unchanged.
REQ-020 LONG_HELD: hcnt not incremented; no further long_press pulses until a new press.
REQ-021 Counters sized to hold their terminal value; no wrap possible under legal parameters.
REQ-022 short_press and long_press shall never assert in the same cycle; at most one pulse per press.

Reset
REQ-023 rst_n=0 shall immediately force state IDLE, synchronizer flops to "released", dcnt=hcnt=0, long flag=0, pressed=0, short_press=0, long_press=0, toggle=0.
REQ-024 Reset asserted mid-press shall discard the press without any pulse; after release of rst_n a still-held button shall be re-debounced from IDLE.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-025 Clean press: btn_n low from edge 1 -> pressed=1 after edge 7; released after 10 cycles -> pressed=0 after 7 more edges, short_press one cycle, toggle 0->1.
REQ-026 Bounce: btn_n low 3 cycles, high 1, low 3, high -> pressed, short_press, toggle stay 0.
REQ-027 Long press: hold 30 cycles after pressed -> long_press one cycle 20 edges after pressed rose; release -> no short_press, toggle unchanged.
REQ-028 Release glitch: while HELD, btn_n high 2 cycles then low -> pressed stays 1, no pulse, hcnt resumes; later release gives exactly one short_press.
REQ-029 Boundary: btn_s falls the cycle hcnt==19 -> no long_press; after release debounce, short_press=1.
REQ-030 Reset mid-hold: rst_n low at hcnt=10 -> all outputs 0 asynchronously; rst_n high with btn_n still low -> pressed re-rises after 7 edges.

Source files
------------

// File: rtl/pushbutton_reader_if.sv
// Signal bundle between a raw active-low pushbutton and its debounced reader.
// The reader sits on the slave side and the stimulus or board sits on the master side.
interface pushbutton_reader_if;
    logic btn_n;
    logic pressed;
    logic short_press;
    logic long_press;
    logic toggle;

    modport master (
        output btn_n,
        input  pressed,
        input  short_press,
        input  long_press,
        input  toggle
    );

    modport slave (
        input  btn_n,
        output pressed,
        output short_press,
        output long_press,
        output toggle
    );
endinterface

// File: rtl/pushbutton_reader.sv
// Debounced pushbutton reader. It reports the held level, short and long press pulses,
// and a toggle that flips on every short press.
module pushbutton_reader #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int LONG_CYCLES     = 20000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pushbutton_reader_if.slave   bus
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        LONG_HELD,
        DEB_RELEASE
    } state_t;

    // Both flops reset to 1 so the synchronizer starts in the released state.
    logic [1:0] sync_reg;
    logic       btn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], bus.btn_n};
        end
    end

    assign btn_s = ~sync_reg[1];

    state_t            state_reg, state_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
    logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
    logic              long_flag_reg, long_flag_next;
    logic              pressed_reg, pressed_next;
    logic              short_reg, short_next;
    logic              long_reg, long_next;
    logic              toggle_reg, toggle_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dcnt_reg      <= '0;
            hcnt_reg      <= '0;
            long_flag_reg <= 1'b0;
            pressed_reg   <= 1'b0;
            short_reg     <= 1'b0;
            long_reg      <= 1'b0;
            toggle_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dcnt_reg      <= dcnt_next;
            hcnt_reg      <= hcnt_next;
            long_flag_reg <= long_flag_next;
            pressed_reg   <= pressed_next;
            short_reg     <= short_next;
            long_reg      <= long_next;
            toggle_reg    <= toggle_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dcnt_next      = dcnt_reg;
        hcnt_next      = hcnt_reg;
        long_flag_next = long_flag_reg;
        pressed_next   = pressed_reg;
        short_next     = 1'b0;
        long_next      = 1'b0;
        toggle_next    = toggle_reg;

        case (state_reg)
            IDLE: begin
                if (btn_s) begin
                    state_next = DEB_PRESS;
                    dcnt_next  = '0;
                end
            end

            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next     = HELD;
                    pressed_next   = 1'b1;
                    hcnt_next      = '0;
                    long_flag_next = 1'b0;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end

            // A release seen on the terminal hold count wins over the long press.
            HELD: begin
                if (!btn_s) begin
                    state_next = DEB_RELEASE;
                    dcnt_next  = '0;
                end else if (hcnt_reg == HCNT_LAST) begin
                    state_next     = LONG_HELD;
                    long_flag_next = 1'b1;
                    long_next      = 1'b1;
                end else begin
                    hcnt_next = hcnt_reg + 1'b1;
                end
            end

            LONG_HELD: begin
                if (!btn_s) begin
                    state_next = DEB_RELEASE;
                    dcnt_next  = '0;
                end
            end

            // A glitch returns to the hold state with hcnt untouched, so hold time resumes.
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_next = long_flag_reg ? LONG_HELD : HELD;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next   = IDLE;
                    pressed_next = 1'b0;
                    if (!long_flag_reg) begin
                        short_next  = 1'b1;
                        toggle_next = ~toggle_reg;
                    end
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pressed     = pressed_reg;
    assign bus.short_press = short_reg;
    assign bus.long_press  = long_reg;
    assign bus.toggle      = toggle_reg;

endmodule
